// File: rtl/memory_stage_pkg.sv
// Shared control-word layout for the memory stage: bit indices into ctrl_i and the ctrl type.
package memory_stage_pkg;

  localparam int unsigned I_MEM_R = 0;
  localparam int unsigned I_MEM_W = 1;
  localparam int unsigned I_WEX   = 2;
  localparam int unsigned I_LB    = 3;
  localparam int unsigned I_LBU   = 4;
  localparam int unsigned I_LH    = 5;
  localparam int unsigned I_LHU   = 6;
  localparam int unsigned I_LWL   = 7;
  localparam int unsigned I_LWR   = 8;
  localparam int unsigned I_MAX   = 9;

  typedef logic [I_MAX-1:0] ctrl_t;

endpackage

// File: rtl/load_align.sv
// Load data alignment: byte/halfword extraction with sign/zero extension and LWL/LWR merging.
module load_align
  import memory_stage_pkg::*;
(
  input  ctrl_t       ctrl_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] mem_data_i,
  input  logic [31:0] rt_old_i,
  output logic [31:0] data_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  inv_sh;
  logic [31:0] shr;
  logic [15:0] half;
  logic        unused_ctrl;

  assign byte_sh = {offset_i, 3'b000};
  // 3 - o equals ~o for a 2-bit offset
  assign inv_sh  = {~offset_i, 3'b000};
  assign shr     = mem_data_i >> byte_sh;
  assign half    = offset_i[1] ? mem_data_i[31:16] : mem_data_i[15:0];

  assign unused_ctrl = ^{ctrl_i[I_MEM_R], ctrl_i[I_MEM_W], ctrl_i[I_WEX]};

  always_comb begin
    data_o = mem_data_i;
    if (ctrl_i[I_LB]) begin
      data_o = {{24{shr[7]}}, shr[7:0]};
    end else if (ctrl_i[I_LBU]) begin
      data_o = {24'd0, shr[7:0]};
    end else if (ctrl_i[I_LH]) begin
      data_o = {{16{half[15]}}, half};
    end else if (ctrl_i[I_LHU]) begin
      data_o = {16'd0, half};
    end else if (ctrl_i[I_LWL]) begin
      data_o = (mem_data_i << inv_sh) | (rt_old_i & (32'h00FF_FFFF >> byte_sh));
    end else if (ctrl_i[I_LWR]) begin
      data_o = shr | (rt_old_i & ~(32'hFFFF_FFFF >> byte_sh));
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: waits for in-order data-cache completions, aligns loads, registers to WB.
// Optional MEM_PERFCNT_EN adds load/store wait-cycle counters.
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  ctrl_t       ctrl_i,
  input  logic [31:0] result_i,
  input  logic [31:0] eaddr_i,
  input  logic [31:0] rdata2_i,
  input  logic [4:0]  waddr_i,
  output logic        ready_o,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output ctrl_t       ctrl_o,
  output logic [31:0] result_o,
  output logic [4:0]  waddr_o,
  output logic [4:0]  fwd_addr,
  output logic [31:0] fwd_data,
  output logic        fwd_ok
`ifdef MEM_PERFCNT_EN
  ,
  output logic [31:0] perfcnt_load_waitdata,
  output logic [31:0] perfcnt_store_waitdata
`endif
);

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  state_e      state_q;
  logic [31:0] rdata_buf_q;
  logic        valid_q;
  logic [31:0] pc_q, inst_q, result_q;
  ctrl_t       ctrl_q;
  logic [4:0]  waddr_q;

  logic        mem, done;
  logic [31:0] sel_rdata, aligned, final_data;
  logic        unused_eaddr;

  assign mem     = valid_i && (ctrl_i[I_MEM_R] || ctrl_i[I_MEM_W]);
  assign done    = !mem || data_data_ok || (state_q == StHold);
  assign ready_o = !valid_i || (done && ready_i);

  // Once stalled in HOLD the cache bus has moved on, so use the captured word
  assign sel_rdata = (state_q == StHold) ? rdata_buf_q : data_rdata;

  load_align u_load_align (
    .ctrl_i     (ctrl_i),
    .offset_i   (eaddr_i[1:0]),
    .mem_data_i (sel_rdata),
    .rt_old_i   (rdata2_i),
    .data_o     (aligned)
  );

  assign final_data   = ctrl_i[I_MEM_R] ? aligned : result_i;
  assign unused_eaddr = ^eaddr_i[31:2];

  assign fwd_addr = valid_i ? waddr_i : 5'd0;
  assign fwd_data = final_data;
  assign fwd_ok   = valid_i && done && ctrl_i[I_WEX];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      rdata_buf_q <= '0;
      valid_q     <= 1'b0;
      pc_q        <= '0;
      inst_q      <= '0;
      ctrl_q      <= '0;
      result_q    <= '0;
      waddr_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mem && !data_data_ok) begin
            state_q <= StWait;
          end else if (mem && !ready_i) begin
            state_q <= StHold;
          end
        end
        StWait: begin
          if (data_data_ok) begin
            state_q <= ready_i ? StIdle : StHold;
          end
        end
        StHold: begin
          if (ready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (data_data_ok && (state_q != StHold)) begin
        rdata_buf_q <= data_rdata;
      end
      if (ready_i) begin
        valid_q  <= valid_i && done;
        pc_q     <= pc_i;
        inst_q   <= inst_i;
        ctrl_q   <= ctrl_i;
        waddr_q  <= waddr_i;
        result_q <= final_data;
      end
    end
  end

  assign valid_o  = valid_q;
  assign pc_o     = pc_q;
  assign inst_o   = inst_q;
  assign ctrl_o   = ctrl_q;
  assign result_o = result_q;
  assign waddr_o  = waddr_q;

`ifdef MEM_PERFCNT_EN
  logic [31:0] perf_load_q, perf_store_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_load_q  <= '0;
      perf_store_q <= '0;
    end else begin
      if (state_q == StWait && ctrl_i[I_MEM_R]) perf_load_q <= perf_load_q + 32'd1;
      if (state_q == StWait && ctrl_i[I_MEM_W]) perf_store_q <= perf_store_q + 32'd1;
    end
  end

  assign perfcnt_load_waitdata  = perf_load_q;
  assign perfcnt_store_waitdata = perf_store_q;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: bench plays the execute stage, data cache and writeback.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        valid_i;
  logic [31:0] pc_i, inst_i, result_i, eaddr_i, rdata2_i;
  ctrl_t       ctrl_i;
  logic [4:0]  waddr_i;
  logic        ready_o, ready_i, valid_o, fwd_ok;
  logic [31:0] pc_o, inst_o, result_o, fwd_data;
  ctrl_t       ctrl_o;
  logic [4:0]  waddr_o, fwd_addr;
`ifdef MEM_PERFCNT_EN
  logic [31:0] perf_ld, perf_st;
  int unsigned exp_ld_wait = 0, exp_st_wait = 0;
`endif

  always #5 clk = ~clk;

  memory_stage dut (
    .clk          (clk),
    .resetn       (resetn),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .valid_i      (valid_i),
    .pc_i         (pc_i),
    .inst_i       (inst_i),
    .ctrl_i       (ctrl_i),
    .result_i     (result_i),
    .eaddr_i      (eaddr_i),
    .rdata2_i     (rdata2_i),
    .waddr_i      (waddr_i),
    .ready_o      (ready_o),
    .ready_i      (ready_i),
    .valid_o      (valid_o),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .ctrl_o       (ctrl_o),
    .result_o     (result_o),
    .waddr_o      (waddr_o),
    .fwd_addr     (fwd_addr),
    .fwd_data     (fwd_data),
    .fwd_ok       (fwd_ok)
`ifdef MEM_PERFCNT_EN
    ,
    .perfcnt_load_waitdata  (perf_ld),
    .perfcnt_store_waitdata (perf_st)
`endif
  );

  typedef enum int {OpAlu, OpSt, OpLw, OpLb, OpLbu, OpLh, OpLhu, OpLwl, OpLwr} op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    ctrl_t       ctrl;
    logic [4:0]  waddr;
    logic [31:0] result;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, got, want);
  endtask

  function automatic ctrl_t op_ctrl(input op_e op, input logic wex);
    ctrl_t c;
    c = '0;
    c[I_WEX] = wex;
    case (op)
      OpSt:  c[I_MEM_W] = 1'b1;
      OpLw:  c[I_MEM_R] = 1'b1;
      OpLb:  begin c[I_MEM_R] = 1'b1; c[I_LB]  = 1'b1; end
      OpLbu: begin c[I_MEM_R] = 1'b1; c[I_LBU] = 1'b1; end
      OpLh:  begin c[I_MEM_R] = 1'b1; c[I_LH]  = 1'b1; end
      OpLhu: begin c[I_MEM_R] = 1'b1; c[I_LHU] = 1'b1; end
      OpLwl: begin c[I_MEM_R] = 1'b1; c[I_LWL] = 1'b1; end
      OpLwr: begin c[I_MEM_R] = 1'b1; c[I_LWR] = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  // Reference: byte-lane view of the load rules
  function automatic logic [31:0] model(input op_e op, input logic [31:0] m, input logic [31:0] ea,
                                        input logic [31:0] rt, input logic [31:0] res);
    int          o;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    o = int'(ea[1:0]);
    b = m[8*o +: 8];
    h = ea[1] ? m[31:16] : m[15:0];
    r = rt;
    case (op)
      OpLw:  r = m;
      OpLb:  r = {{24{b[7]}}, b};
      OpLbu: r = {24'd0, b};
      OpLh:  r = {{16{h[15]}}, h};
      OpLhu: r = {16'd0, h};
      OpLwl: for (int i = 0; i <= o; i++) r[8*(3-i) +: 8] = m[8*(o-i) +: 8];
      OpLwr: for (int i = o; i < 4; i++) r[8*(i-o) +: 8] = m[8*i +: 8];
      default: r = res;
    endcase
    return r;
  endfunction

  // Present one instruction until accepted; called and returns at posedge+1
  task automatic issue(input op_e op, input logic wex, input logic [31:0] pc, input logic [31:0] ea,
                       input logic [31:0] rt, input logic [31:0] res, input logic [4:0] wa,
                       input int lat, input logic [31:0] rdata, input int stall, input bit rnd_rdy);
    ctrl_t       c;
    bit          is_mem, accepted, done_e;
    int          resp_k;
    logic [31:0] expv, inst;
    exp_t        e;
    c        = op_ctrl(op, wex);
    is_mem   = (op != OpAlu);
    accepted = 1'b0;
    resp_k   = -1;
    expv     = model(op, rdata, ea, rt, res);
    inst     = pc ^ 32'h0BAD_F00D;
    for (int k = 0; k < 60 && !accepted; k++) begin
      valid_i  = 1'b1;
      pc_i     = pc;
      inst_i   = inst;
      ctrl_i   = c;
      result_i = res;
      eaddr_i  = ea;
      rdata2_i = rt;
      waddr_i  = wa;
      data_data_ok = is_mem && (k == lat);
      data_rdata   = data_data_ok ? rdata : $urandom;
      if (data_data_ok) resp_k = k;
      if (rnd_rdy) ready_i = ($urandom_range(0, 3) != 0);
      else ready_i = !(resp_k >= 0 && k >= resp_k && k < resp_k + stall);
      done_e = !is_mem || (resp_k >= 0);
      @(negedge clk);
      chk("ready_o", 32'(ready_o), 32'(done_e && ready_i));
      chk("fwd_ok", 32'(fwd_ok), 32'(done_e && wex));
      chk("fwd_addr", 32'(fwd_addr), 32'(wa));
      if (done_e) chk("fwd_data", fwd_data, expv);
      if (ready_o) begin
        accepted = 1'b1;
        e = '{pc: pc, inst: inst, ctrl: c, waddr: wa, result: expv};
        sb_q.push_back(e);
`ifdef MEM_PERFCNT_EN
        if (c[I_MEM_R]) exp_ld_wait += lat;
        else if (c[I_MEM_W]) exp_st_wait += lat;
`endif
      end
      @(posedge clk);
      #1;
    end
    data_data_ok = 1'b0;
    if (!accepted) begin
      n_checks++;
      $display("FAIL accept_timeout: pc %08h not accepted within 60 cycles", pc);
    end
  endtask

  task automatic idle(input int n, input bit rnd_rdy);
    for (int k = 0; k < n; k++) begin
      valid_i      = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = $urandom;
      ctrl_i       = ctrl_t'($urandom);
      waddr_i      = 5'($urandom);
      ready_i      = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      chk("idle_ready_o", 32'(ready_o), 32'd1);
      chk("idle_fwd_addr", 32'(fwd_addr), 32'd0);
      chk("idle_fwd_ok", 32'(fwd_ok), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_regs();
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_pc_o", pc_o, 32'd0);
    chk("rst_inst_o", inst_o, 32'd0);
    chk("rst_ctrl_o", 32'(ctrl_o), 32'd0);
    chk("rst_result_o", result_o, 32'd0);
    chk("rst_waddr_o", 32'(waddr_o), 32'd0);
    chk("rst_ready_o", 32'(ready_o), 32'd1);
  endtask

  // Writeback side: each cycle with valid_o && ready_i retires one output
  always @(negedge clk) begin
    if (resetn && valid_o && ready_i) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: valid_o with empty queue, pc_o %08h", pc_o);
      end else begin
        mon_e = sb_q.pop_front();
        chk("pc_o", pc_o, mon_e.pc);
        chk("inst_o", inst_o, mon_e.inst);
        chk("ctrl_o", 32'(ctrl_o), 32'(mon_e.ctrl));
        chk("waddr_o", 32'(waddr_o), 32'(mon_e.waddr));
        chk("result_o", result_o, mon_e.result);
      end
    end
  end

  initial begin
    op_e op;
    resetn = 1'b0; valid_i = 1'b0; data_data_ok = 1'b0; data_rdata = '0; ready_i = 1'b1;
    pc_i = '0; inst_i = '0; ctrl_i = '0; result_i = '0; eaddr_i = '0; rdata2_i = '0; waddr_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_regs();
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // LB zero-latency with sign extension
    issue(OpLb, 1'b1, 32'h100, 32'h1000_0002, 32'h1234_5678, 32'h0, 5'd3, 0, 32'h80FF_1234, 0, 1'b0);
    chk("lb_valid_o", 32'(valid_o), 32'd1);
    chk("lb_result_o", result_o, 32'hFFFF_FFFF);
    issue(OpLwl, 1'b1, 32'h104, 32'h2000_0001, 32'h1122_3344, 32'h0, 5'd4, 1, 32'hAABB_CCDD, 0, 1'b0);
    chk("lwl_result_o", result_o, 32'hCCDD_3344);
    issue(OpLwr, 1'b1, 32'h108, 32'h2000_0001, 32'h1122_3344, 32'h0, 5'd5, 0, 32'hAABB_CCDD, 0, 1'b0);
    chk("lwr_result_o", result_o, 32'h11AA_BBCC);
    // Delayed response, then responses landing on a stalled writeback
    issue(OpLw, 1'b1, 32'h10C, 32'h0, 32'h0, 32'h0, 5'd6, 3, 32'hCAFE_0001, 0, 1'b0);
    issue(OpLw, 1'b1, 32'h110, 32'h0, 32'h0, 32'h0, 5'd7, 0, 32'hCAFE_0002, 2, 1'b0);
    issue(OpLh, 1'b1, 32'h114, 32'h2, 32'h0, 32'h0, 5'd8, 2, 32'h9ABC_0000, 2, 1'b0);
    issue(OpAlu, 1'b1, 32'h118, 32'h0, 32'h0, 32'h5, 5'd9, 0, 32'h0, 0, 1'b0);
    chk("addu_result_o", result_o, 32'h5);
    issue(OpSt, 1'b0, 32'h11C, 32'h4, 32'h0, 32'h77, 5'd0, 1, 32'h0, 0, 1'b0);

    // Reset while waiting for a load response
    valid_i = 1'b1; pc_i = 32'h200; inst_i = 32'h1; ctrl_i = op_ctrl(OpLw, 1'b1);
    waddr_i = 5'd10; data_data_ok = 1'b0; ready_i = 1'b1;
    @(negedge clk);
    chk("wait_ready_o", 32'(ready_o), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(negedge clk);
    chk("wait_fwd_ok", 32'(fwd_ok), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    valid_i = 1'b0;
    sb_q.delete();
`ifdef MEM_PERFCNT_EN
    exp_ld_wait = 0;
    exp_st_wait = 0;
`endif
    @(negedge clk);
    chk_reset_regs();
    @(posedge clk);
    #1;
    // Stale buffer or leftover state would corrupt this one
    issue(OpLbu, 1'b1, 32'h204, 32'h3, 32'h0, 32'h0, 5'd11, 0, 32'h5A00_0000, 1, 1'b0);

    for (int n = 0; n < 300; n++) begin
      op = op_e'($urandom_range(0, 8));
      issue(op, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom, 5'($urandom),
            $urandom_range(0, 4), $urandom, 0, 1'b1);
      if ($urandom_range(0, 4) == 0) idle(1, 1'b1);
    end
    idle(4, 1'b0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
`ifdef MEM_PERFCNT_EN
    chk("perf_load", perf_ld, exp_ld_wait);
    chk("perf_store", perf_st, exp_st_wait);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameters: none; control width is `I_MAX, taken from common.vh.
REQ-002 clk  in  1  sole clock.
REQ-003 resetn  in  1  reset; synchronous, active-low, sampled on posedge clk.
REQ-004 data_data_ok  in  1  in-order completion pulse from data cache, one per accepted request (load or store).
REQ-005 data_rdata  in  32  load data, valid with data_data_ok.
REQ-006 valid_i, pc_i[32], inst_i[32], ctrl_i[`I_MAX], result_i[32], eaddr_i[32], rdata2_i[32], waddr_i[5]  in  instruction from execute stage.
REQ-007 ready_o  out  1  may accept a new instruction this cycle (drives execute stage ready_i).
REQ-008 ready_i  in  1  writeback stage accepts this cycle.
REQ-009 valid_o, pc_o[32], inst_o[32], ctrl_o[`I_MAX], result_o[32], waddr_o[5]  out  registered instruction to writeback.
REQ-010 fwd_addr[5], fwd_data[32], fwd_ok[1]  out  forwarding to decode.

Function
REQ-011 mem = valid_i && (ctrl_i[`I_MEM_R] || ctrl_i[`I_MEM_W]); each such instruction owns exactly one outstanding cache request.
REQ-012 FSM states: IDLE (no response pending), WAIT (mem op, response not yet received), HOLD (response received, buffered, downstream stalled).
REQ-013 IDLE->WAIT when mem and !data_data_ok; IDLE->HOLD when mem && data_data_ok && !ready_i; otherwise stay IDLE.
REQ-014 WAIT->IDLE on data_data_ok && ready_i; WAIT->HOLD on data_data_ok && !ready_i.
REQ-015 HOLD->IDLE on ready_i; data_data_ok in HOLD is illegal (must never occur).
REQ-016 On data_data_ok in IDLE/WAIT, data_rdata is captured into rdata_buf; in HOLD the load result uses rdata_buf, otherwise data_rdata directly.
REQ-017 done = !mem || data_data_ok || state==HOLD; ready_o = !valid_i || (done && ready_i).
REQ-018 Load alignment, o = eaddr_i[1:0], m = selected read data:
 LW: m; LB/LBU: byte o, sign/zero-extended; LH/LHU: halfword o[1], sign/zero-extended;
 LWL: (m << 8*(3-o)) | (rdata2_i & (32'h00FFFFFF >> 8*o));
 LWR: (m >> 8*o) | (rdata2_i & ~(32'hFFFFFFFF >> 8*o)).
REQ-019 final = ctrl_i[`I_MEM_R] ? aligned load : result_i; stores pass result_i.
REQ-020 On ready_i: valid_o <= valid_i && done; pc_o/inst_o/ctrl_o/waddr_o <= inputs; result_o <= final.
REQ-021 fwd_addr = valid_i ? waddr_i : 0; fwd_data = final; fwd_ok = valid_i && done && ctrl_i[`I_WEX].
REQ-022 Zero-latency: a non-memory instruction or a load whose data_data_ok arrives in its first cycle reaches valid_o on the next edge when ready_i=1.

Reset
REQ-023 When resetn=0 at posedge clk: state=IDLE, valid_o=0, pc_o/inst_o/result_o=0, ctrl_o=0, waddr_o=0, rdata_buf=0; reset mid-WAIT discards the pending response.
REQ-024 Combinational outputs during reset follow inputs; ready_o=1 when valid_i=0.

Configuration
REQ-025 Macro MEM_PERFCNT_EN: when defined, adds output perfcnt_load_waitdata[32], reset to 0, incremented each cycle state==WAIT && ctrl_i[`I_MEM_R], plus perfcnt_store_waitdata[32] likewise for `I_MEM_W; when undefined, these ports and counters do not exist and all other behaviour is identical.

Structure
REQ-026 `I_* control indices, `I_MAX and GET_* field macros come from common.vh; the FSM state encodings are defined as localparams inside the module.
REQ-027 Alignment logic (REQ-018) is a combinational sub-module load_align (inputs ctrl, offset, mem data, rt old; output 32-bit data).

Verification
REQ-028 LB, eaddr=0x...2, data_data_ok with rdata=0x80FF1234 in the same cycle, ready_i=1 -> next cycle valid_o=1, result_o=0xFFFFFFFF.
REQ-029 LWL, o=1, rdata=0xAABBCCDD, rdata2=0x11223344 -> result_o=0xCCDD3344; LWR, o=1 -> 0x11AABBCC.
REQ-030 LW, data_data_ok delayed 3 cycles -> WAIT for 3 cycles, ready_o=0 and fwd_ok=0 throughout; result written on the response cycle.
REQ-031 LW, data_data_ok arrives while ready_i=0 for 2 cycles -> HOLD; rdata_buf is held; on ready_i=1, result_o equals the buffered data and the state returns to IDLE.
REQ-032 ADDU with result_i=0x5, WEX set -> fwd_ok=1, fwd_data=0x5 in the same cycle; resetn=0 during WAIT -> next cycle state=IDLE, valid_o=0.
REQ-033 MEM_PERFCNT_EN defined, load waits 4 cycles -> perfcnt_load_waitdata=4.
